// File: rtl/fv_enc_pkg.sv
// Shared types and constants for the FV encryption multiplier scheduler.
package fv_enc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED0,
    S_DRAIN0,
    S_FEED1,
    S_DRAIN1
  } sched_state_t;

  localparam logic C_SEL_C0 = 1'b0;
  localparam logic C_SEL_C1 = 1'b1;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/u_coeff_buf.sv
// N x UW register file holding the u polynomial between the two multiplier passes.
module u_coeff_buf
  import fv_enc_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned UW = 1,
  parameter int unsigned AW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [UW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [UW-1:0] rdata
);

  logic [UW-1:0] mem [N];

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fv_enc_mult_sched.sv
// Runs the shared polynomial multiplier twice per FV encryption: p0*u, then p1*u
// with u replayed from a local buffer; products are tagged and passed downstream.
module fv_enc_mult_sched
  import fv_enc_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned QW = 64,
  parameter int unsigned UW = 1
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          start,
  input  logic [QW-1:0] p0_data,
  input  logic          p0_vld,
  input  logic          p0_last,
  output logic          p0_rdy,
  input  logic [QW-1:0] p1_data,
  input  logic          p1_vld,
  input  logic          p1_last,
  output logic          p1_rdy,
  input  logic [UW-1:0] u_data,
  input  logic          u_vld,
  input  logic          u_last,
  output logic          u_rdy,
  output logic [QW-1:0] mp_data,
  output logic          mp_vld,
  output logic          mp_last,
  input  logic          mp_rdy,
  output logic [UW-1:0] mu_data,
  output logic          mu_vld,
  output logic          mu_last,
  input  logic          mu_rdy,
  input  logic [QW-1:0] mz_data,
  input  logic          mz_vld,
  input  logic          mz_last,
  output logic          mz_rdy,
  output logic [QW-1:0] c_data,
  output logic          c_vld,
  output logic          c_last,
  input  logic          c_rdy,
  output logic          c_sel,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned   CW       = cnt_w(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  sched_state_t  state, state_nxt;
  logic [CW-1:0] cnt;
  logic [UW-1:0] buf_rdata;
  logic          last_pos, xfer, buf_we;
  logic          len_err, stray_err, bp_err;
  logic          job_start, job_end;

  assign last_pos = (cnt == CNT_LAST);
  assign buf_we   = xfer && (state == S_FEED0);
  assign busy     = (state != S_IDLE);

  u_coeff_buf #(
    .N (N),
    .UW(UW)
  ) u_buf (
    .clk  (clk),
    .a_rst(a_rst),
    .we   (buf_we),
    .waddr(cnt),
    .wdata(u_data),
    .raddr(cnt),
    .rdata(buf_rdata)
  );

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= job_end;
      if (job_start) begin
        cnt <= '0;
      end else if (xfer) begin
        cnt <= last_pos ? '0 : cnt + CW'(1);
      end
      err <= (err & ~job_start) | len_err | stray_err | bp_err;
    end
  end

  always_comb begin
    state_nxt = state;
    p0_rdy    = 1'b0;
    p1_rdy    = 1'b0;
    u_rdy     = 1'b0;
    mp_data   = '0;
    mp_vld    = 1'b0;
    mp_last   = 1'b0;
    mu_data   = '0;
    mu_vld    = 1'b0;
    mu_last   = 1'b0;
    mz_rdy    = 1'b0;
    c_data    = '0;
    c_vld     = 1'b0;
    c_last    = 1'b0;
    c_sel     = C_SEL_C0;
    xfer      = 1'b0;
    len_err   = 1'b0;
    stray_err = 1'b0;
    bp_err    = 1'b0;
    job_start = 1'b0;
    job_end   = 1'b0;

    unique case (state)
      S_IDLE: begin
        stray_err = mz_vld;
        if (start) begin
          job_start = 1'b1;
          state_nxt = S_FEED0;
        end
      end
      S_FEED0: begin
        stray_err = mz_vld;
        mp_data   = p0_data;
        mu_data   = u_data;
        mp_vld    = p0_vld & u_vld;
        mu_vld    = p0_vld & u_vld;
        mp_last   = last_pos;
        mu_last   = last_pos;
        xfer      = mp_rdy & mu_rdy & p0_vld & u_vld;
        p0_rdy    = xfer;
        u_rdy     = xfer;
        // Length is fixed at N; a misplaced or missing last only flags err.
        len_err   = xfer & (last_pos ? ~(p0_last & u_last) : (p0_last | u_last));
        if (xfer && last_pos) state_nxt = S_DRAIN0;
      end
      S_FEED1: begin
        stray_err = mz_vld;
        mp_data   = p1_data;
        mu_data   = buf_rdata;
        mp_vld    = p1_vld;
        mu_vld    = p1_vld;
        mp_last   = last_pos;
        mu_last   = last_pos;
        xfer      = mp_rdy & mu_rdy & p1_vld;
        p1_rdy    = xfer;
        len_err   = xfer & (last_pos ? ~p1_last : p1_last);
        if (xfer && last_pos) state_nxt = S_DRAIN1;
      end
      S_DRAIN0, S_DRAIN1: begin
        mz_rdy = 1'b1;
        c_data = mz_data;
        c_vld  = mz_vld;
        c_last = mz_last;
        c_sel  = (state == S_DRAIN1) ? C_SEL_C1 : C_SEL_C0;
        bp_err = mz_vld & ~c_rdy;
        if (mz_vld && mz_last) begin
          if (state == S_DRAIN0) begin
            state_nxt = S_FEED1;
          end else begin
            state_nxt = S_IDLE;
            job_end   = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fv_enc_mult_sched.sv
// Bench for fv_enc_mult_sched: a behavioural negacyclic multiplier sits on mp/mu/mz,
// and c streams are compared with products computed directly from the job stimulus.
module tb_fv_enc_mult_sched;

  localparam int N  = 16;
  localparam int QW = 64;
  localparam int UW = 1;

  typedef logic [QW-1:0] poly_t [N];

  typedef struct {
    int pat;        // 0 ramp, 1 negacyclic replay, 2 random
    int stall;      // percent of cycles each source withholds vld
    int bad_last;   // p0 coefficient carrying a premature last, -1 none
    int bp_drop;    // drain1 coefficient with c_rdy low, -1 none
    bit start_busy; // hold start high through drain0
    bit exp_err;    // err expected at end of job
  } job_t;

  logic clk = 1'b0;
  logic a_rst, start;
  logic [QW-1:0] p0_data, p1_data, mp_data, mz_data, c_data;
  logic [UW-1:0] u_data, mu_data;
  logic p0_vld, p0_last, p0_rdy, p1_vld, p1_last, p1_rdy, u_vld, u_last, u_rdy;
  logic mp_vld, mp_last, mp_rdy, mu_vld, mu_last, mu_rdy;
  logic mz_vld, mz_last, mz_rdy, c_vld, c_last, c_rdy;
  logic c_sel, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fv_enc_mult_sched #(.N(N), .QW(QW), .UW(UW)) dut (
    .clk(clk), .a_rst(a_rst), .start(start),
    .p0_data(p0_data), .p0_vld(p0_vld), .p0_last(p0_last), .p0_rdy(p0_rdy),
    .p1_data(p1_data), .p1_vld(p1_vld), .p1_last(p1_last), .p1_rdy(p1_rdy),
    .u_data(u_data), .u_vld(u_vld), .u_last(u_last), .u_rdy(u_rdy),
    .mp_data(mp_data), .mp_vld(mp_vld), .mp_last(mp_last), .mp_rdy(mp_rdy),
    .mu_data(mu_data), .mu_vld(mu_vld), .mu_last(mu_last), .mu_rdy(mu_rdy),
    .mz_data(mz_data), .mz_vld(mz_vld), .mz_last(mz_last), .mz_rdy(mz_rdy),
    .c_data(c_data), .c_vld(c_vld), .c_last(c_last), .c_rdy(c_rdy),
    .c_sel(c_sel), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Product in Z_Q[x]/(x^N+1) with Q = 2^64, straight from the definition.
  function automatic poly_t negmul(input poly_t p, input logic [N-1:0] u);
    poly_t r;
    for (int k = 0; k < N; k++) r[k] = '0;
    for (int i = 0; i < N; i++) begin
      if (u[i]) begin
        for (int j = 0; j < N; j++) begin
          if (i + j < N) r[i + j] = r[i + j] + p[j];
          else r[i + j - N] = r[i + j - N] - p[j];
        end
      end
    end
    return r;
  endfunction

  task automatic run_job(input string tag, input poly_t p0s, input poly_t p1s,
                         input logic [N-1:0] us, input int stall, input int bad_last,
                         input int bp_drop, input int rst_at, input bit start_busy,
                         input bit exp_err);
    poly_t e0, e1, cap_p, prod;
    logic [N-1:0] cap_u;
    int idx, ncap, cyc;
    bit bad_hs, bad_lt, src, pv, uv, just_bad, seen_done;
    e0 = negmul(p0s, us);
    e1 = negmul(p1s, us);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk1({tag, "_busy_after_start"}, busy, 1'b1);
    chk1({tag, "_err_at_start"}, err, 1'b0);
    for (int ph = 0; ph < 2; ph++) begin
      idx = 0; ncap = 0; cyc = 0; bad_hs = 0; bad_lt = 0;
      for (int k = 0; k < N; k++) cap_p[k] = '0;
      cap_u = '0;
      while (idx < N && cyc < 400) begin
        cyc++;
        pv = ($urandom_range(99) >= stall);
        uv = ($urandom_range(99) >= stall);
        if (ph == 0) begin
          p0_vld = pv; p0_data = p0s[idx]; p0_last = (idx == N - 1) || (idx == bad_last);
          u_vld = uv; u_data = us[idx]; u_last = (idx == N - 1);
        end else begin
          p1_vld = pv; p1_data = p1s[idx]; p1_last = (idx == N - 1);
          u_vld = uv; u_data = 1'($urandom); u_last = 1'b0;
        end
        #1;
        src = (ph == 0) ? (p0_rdy && u_rdy) : p1_rdy;
        if (ph == 0 && (p0_rdy != u_rdy)) bad_hs = 1;
        if (ph == 1 && (u_rdy || p0_rdy)) bad_hs = 1;
        if (src && !((ph == 0) ? (p0_vld && u_vld) : p1_vld)) bad_hs = 1;
        if ((mp_vld && mu_vld) != src) bad_hs = 1;
        if (mp_vld && mu_vld && ncap < N) begin
          if (mp_last != (ncap == N - 1) || mu_last != (ncap == N - 1)) bad_lt = 1;
          cap_p[ncap] = mp_data;
          cap_u[ncap] = mu_data[0];
          ncap++;
        end
        just_bad = (ph == 0) && src && (idx == bad_last);
        if (src) idx++;
        @(posedge clk);
        @(negedge clk);
        if (just_bad) begin
          #1;
          chk1({tag, "_err_on_bad_last"}, err, 1'b1);
        end
      end
      p0_vld = 0; p1_vld = 0; u_vld = 0; p0_last = 0; p1_last = 0; u_last = 0;
      chk1($sformatf("%s_feed%0d_complete", tag, ph), (idx == N), 1'b1);
      chk1($sformatf("%s_feed%0d_handshake_bad", tag, ph), bad_hs, 1'b0);
      chk1($sformatf("%s_feed%0d_mlast_bad", tag, ph), bad_lt, 1'b0);
      prod = negmul(cap_p, cap_u);
      for (int k = 0; k < N; k++) begin
        mz_vld = 1'b1; mz_data = prod[k]; mz_last = (k == N - 1);
        c_rdy = !(ph == 1 && k == bp_drop);
        if (ph == 0 && start_busy) start = 1'b1;
        if (ph == 0 && k == rst_at) begin
          a_rst = 1'b1;
          #1;
          chk1({tag, "_rst_c_vld"}, c_vld, 1'b0);
          chk1({tag, "_rst_c_last"}, c_last, 1'b0);
          chk1({tag, "_rst_busy"}, busy, 1'b0);
          chk1({tag, "_rst_mz_rdy"}, mz_rdy, 1'b0);
          chk1({tag, "_rst_mp_vld"}, mp_vld, 1'b0);
          chk1({tag, "_rst_err"}, err, 1'b0);
          mz_vld = 0; mz_last = 0; start = 0;
          @(negedge clk);
          a_rst = 1'b0;
          seen_done = 0;
          repeat (3) begin
            @(negedge clk);
            #1;
            if (done) seen_done = 1;
          end
          chk1({tag, "_rst_no_done"}, seen_done, 1'b0);
          return;
        end
        #1;
        chk($sformatf("%s_c%0d_data[%0d]", tag, ph, k), c_data, (ph == 1) ? e1[k] : e0[k]);
        chk1($sformatf("%s_c%0d_vld[%0d]", tag, ph, k), c_vld, 1'b1);
        chk1($sformatf("%s_c%0d_last[%0d]", tag, ph, k), c_last, (k == N - 1));
        chk1($sformatf("%s_c%0d_sel[%0d]", tag, ph, k), c_sel, (ph == 1));
        @(posedge clk);
        @(negedge clk);
      end
      mz_vld = 0; mz_last = 0; c_rdy = 1'b1; start = 1'b0;
    end
    #1;
    chk1({tag, "_done_pulse"}, done, 1'b1);
    chk1({tag, "_idle_after_job"}, busy, 1'b0);
    chk1({tag, "_err_end"}, err, exp_err);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk1({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  job_t jobs[7];
  poly_t ramp0, ramp1, onehot15, rnd0, rnd1;
  poly_t q0, q1;
  logic [N-1:0] qu;

  initial begin
    jobs[0] = '{pat: 0, stall: 0,  bad_last: -1, bp_drop: -1, start_busy: 0, exp_err: 0};
    jobs[1] = '{pat: 1, stall: 0,  bad_last: -1, bp_drop: -1, start_busy: 0, exp_err: 0};
    jobs[2] = '{pat: 0, stall: 40, bad_last: -1, bp_drop: -1, start_busy: 0, exp_err: 0};
    jobs[3] = '{pat: 0, stall: 0,  bad_last: 9,  bp_drop: -1, start_busy: 0, exp_err: 1};
    jobs[4] = '{pat: 2, stall: 25, bad_last: -1, bp_drop: -1, start_busy: 1, exp_err: 0};
    jobs[5] = '{pat: 0, stall: 0,  bad_last: -1, bp_drop: 3,  start_busy: 0, exp_err: 1};
    jobs[6] = '{pat: 2, stall: 10, bad_last: -1, bp_drop: -1, start_busy: 0, exp_err: 0};

    for (int i = 0; i < N; i++) begin
      ramp0[i] = QW'(i);
      ramp1[i] = QW'(100 + i);
      onehot15[i] = (i == N - 1) ? 64'd1 : 64'd0;
    end

    a_rst = 1'b1; start = 0;
    p0_data = '0; p0_vld = 0; p0_last = 0; p1_data = '0; p1_vld = 0; p1_last = 0;
    u_data = '0; u_vld = 0; u_last = 0; mp_rdy = 1'b1; mu_rdy = 1'b1;
    mz_data = '0; mz_vld = 0; mz_last = 0; c_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", err, 1'b0);
    chk1("reset_c_sel", c_sel, 1'b0);
    chk1("reset_c_vld", c_vld, 1'b0);
    chk1("reset_mp_vld", mp_vld, 1'b0);
    chk1("reset_mz_rdy", mz_rdy, 1'b0);
    @(negedge clk);
    a_rst = 1'b0;

    for (int j = 0; j < 7; j++) begin
      for (int i = 0; i < N; i++) begin
        rnd0[i] = {$urandom, $urandom};
        rnd1[i] = {$urandom, $urandom};
      end
      case (jobs[j].pat)
        0: begin q0 = ramp0; q1 = ramp1; qu = N'(1); end
        1: begin q0 = ramp0; q1 = onehot15; qu = N'(2); end
        default: begin q0 = rnd0; q1 = rnd1; qu = N'($urandom); end
      endcase
      run_job($sformatf("job%0d", j), q0, q1, qu, jobs[j].stall, jobs[j].bad_last,
              jobs[j].bp_drop, -1, jobs[j].start_busy, jobs[j].exp_err);
    end

    // Idle: sources are never acknowledged, stray multiplier output is dropped.
    @(negedge clk);
    p0_vld = 1; u_vld = 1; p1_vld = 1; mz_vld = 1; mz_data = 64'hdead;
    #1;
    chk1("idle_p0_rdy", p0_rdy, 1'b0);
    chk1("idle_u_rdy", u_rdy, 1'b0);
    chk1("idle_p1_rdy", p1_rdy, 1'b0);
    chk1("idle_mp_vld", mp_vld, 1'b0);
    chk1("idle_stray_c_vld", c_vld, 1'b0);
    @(negedge clk);
    p0_vld = 0; u_vld = 0; p1_vld = 0; mz_vld = 0;
    #1;
    chk1("idle_stray_err", err, 1'b1);

    // Abort during drain0, then a clean job must still produce correct results.
    run_job("rst_job", ramp0, ramp1, N'(1), 0, -1, -1, 5, 0, 0);
    run_job("post_rst", ramp0, ramp1, N'(1), 0, -1, -1, -1, 0, 0);
    run_job("post_rst_neg", ramp0, onehot15, N'(2), 20, -1, -1, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
